// File: rtl/tmr_pkg.sv
// Shared constants for the timer input-capture unit: edge-select codes,
// capture FSM state encoding and the default timer width.
package tmr_pkg;

    localparam int TMR_W = 16;

    localparam logic [1:0] EDGE_NONE = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } cap_state_e;

endpackage

// File: rtl/cap_fifo.sv
// Small synchronous capture FIFO with show-ahead head data.
// A pop on a full FIFO frees a slot in the same cycle, so push and pop together
// always succeed while the FIFO holds at least one entry.
module cap_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  data_i,
    output logic [W-1:0]  data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = empty_o ? '0 : mem_q[rd_q];
    assign count_o = cnt_q;

    // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Entry storage; contents are only visible through data_o when non-empty
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/tmr_capture.sv
// Input-capture unit: synchronises CAP_IN, detects the selected edge(s) and
// queues the timer value for the CPU. CAP_IRQ is a level tracking CAP_VALID.
// Optional build macro CAP_DELTA_EN: queue ticks elapsed since the previous
// capture (wrapping through PR) instead of the raw TMR value.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | capture disabled; FIFO, overflow flag and edge history held clear
// ST_ARM  | one settling cycle: history loads the synced pin, no edges
// ST_RUN  | edges detected and pushed into the FIFO
module tmr_capture
    import tmr_pkg::*;
#(
    parameter int W     = TMR_W,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    EN_CAP,
    input  logic [1:0]              EDGE_SEL,
    input  logic                    CAP_IN,
    input  logic [W-1:0]            TMR,
    input  logic [W-1:0]            PR,
    input  logic                    CAP_RD,
    input  logic                    OVF_CLR,
    output logic [W-1:0]            CAP_DATA,
    output logic                    CAP_VALID,
    output logic [$clog2(DEPTH):0]  CAP_CNT,
    output logic                    CAP_OVF,
    output logic                    CAP_IRQ
);

    cap_state_e state_q;
    cap_state_e state_d;
    logic       sync1_q;
    logic       sync2_q;
    logic       hist_q;
    logic       hist_d;
    logic       edge_q;
    logic       edge_d;
    logic       edge_hit;
    logic       flush;
    logic       cap_evt;
    logic       fifo_full;
    logic       fifo_empty;
    logic       drop;
    logic       ovf_q;
    logic       ovf_d;
    logic [W-1:0] push_val;

    // Two-flop synchroniser on the asynchronous pin
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= CAP_IN;
            sync2_q <= sync1_q;
        end
    end

    // Edge qualification against the current edge selection
    always_comb begin
        edge_hit = 1'b0;
        case (EDGE_SEL)
            EDGE_NONE: edge_hit = 1'b0;
            EDGE_RISE: edge_hit = sync2_q & ~hist_q;
            EDGE_FALL: edge_hit = ~sync2_q & hist_q;
            EDGE_BOTH: edge_hit = sync2_q ^ hist_q;
            default:   edge_hit = 1'b0;
        endcase
    end

    // Next state, history load and registered edge pulse
    always_comb begin
        state_d = state_q;
        hist_d  = sync2_q;
        edge_d  = 1'b0;
        flush   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                hist_d = 1'b0;
                flush  = 1'b1;
                if (EN_CAP) state_d = ST_ARM;
            end
            ST_ARM:  state_d = ST_RUN;
            ST_RUN:  edge_d  = edge_hit;
            default: begin
                state_d = ST_IDLE;
                hist_d  = 1'b0;
                flush   = 1'b1;
            end
        endcase
        if (!EN_CAP) begin
            state_d = ST_IDLE;
            hist_d  = 1'b0;
            edge_d  = 1'b0;
            flush   = 1'b1;
        end
    end

    // FSM, history and edge-pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            hist_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            edge_q  <= edge_d;
        end
    end

    assign cap_evt = edge_q & (state_q == ST_RUN) & EN_CAP;
    assign drop    = cap_evt & fifo_full & ~CAP_RD;

`ifdef CAP_DELTA_EN
    logic [W-1:0] last_q;
    logic [W-1:0] last_d;
    logic         primed_q;
    logic         primed_d;
    logic [W:0]   delta_w;

    // Elapsed ticks since the last capture; dropped captures still move `last`
    always_comb begin
        if (TMR >= last_q) delta_w = {1'b0, TMR} - {1'b0, last_q};
        else               delta_w = {1'b0, TMR} + {1'b0, PR} + (W+1)'(1) - {1'b0, last_q};
        last_d   = last_q;
        primed_d = primed_q;
        push_val = '0;
        if (state_q != ST_RUN) primed_d = 1'b0;
        if (cap_evt) begin
            last_d   = TMR;
            primed_d = 1'b1;
            push_val = primed_q ? W'(delta_w) : '0;
        end
    end

    // Reference point for delta captures
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q   <= '0;
            primed_q <= 1'b0;
        end else begin
            last_q   <= last_d;
            primed_q <= primed_d;
        end
    end
`else
    logic unused_pr;

    assign push_val  = TMR;
    assign unused_pr = ^PR;
`endif

    // Sticky overflow: a drop in the same cycle as OVF_CLR keeps the flag set
    always_comb begin
        ovf_d = ovf_q;
        if (flush)        ovf_d = 1'b0;
        else if (drop)    ovf_d = 1'b1;
        else if (OVF_CLR) ovf_d = 1'b0;
    end

    // Overflow flag register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ovf_q <= 1'b0;
        else      ovf_q <= ovf_d;
    end

    cap_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (cap_evt),
        .pop_i   (CAP_RD),
        .data_i  (push_val),
        .data_o  (CAP_DATA),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (CAP_CNT)
    );

    assign CAP_VALID = ~fifo_empty;
    assign CAP_IRQ   = ~fifo_empty;
    assign CAP_OVF   = ovf_q;

endmodule

// File: tb/tb_tmr_capture.sv
// Bench for tmr_capture: directed vector table, randomized run against a
// queue-based reference model, delta-mode sequence and asynchronous reset.
module tb_tmr_capture;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          EN_CAP;
    logic [1:0]    EDGE_SEL;
    logic          CAP_IN;
    logic [W-1:0]  TMR;
    logic [W-1:0]  PR;
    logic          CAP_RD;
    logic          OVF_CLR;
    logic [W-1:0]  CAP_DATA;
    logic          CAP_VALID;
    logic [2:0]    CAP_CNT;
    logic          CAP_OVF;
    logic          CAP_IRQ;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int tmr    = 0;
    int pr     = 65535;

    assign TMR = tmr[W-1:0];
    assign PR  = pr[W-1:0];

    always #5 clk = ~clk;

    tmr_capture #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .EN_CAP    (EN_CAP),
        .EDGE_SEL  (EDGE_SEL),
        .CAP_IN    (CAP_IN),
        .TMR       (TMR),
        .PR        (PR),
        .CAP_RD    (CAP_RD),
        .OVF_CLR   (OVF_CLR),
        .CAP_DATA  (CAP_DATA),
        .CAP_VALID (CAP_VALID),
        .CAP_CNT   (CAP_CNT),
        .CAP_OVF   (CAP_OVF),
        .CAP_IRQ   (CAP_IRQ)
    );

    // Reference model: pin changes become pushes three edges later; FIFO is a queue.
    logic [W-1:0] m_q[$];
    int           m_due[$];
    bit           m_ovf      = 0;
    bit           m_primed   = 0;
    int           m_last     = 0;
    bit           m_prev_pin = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit push_now;
        bit pop_now;
        bit drop;
        int v;
        v = 0;
        if (!EN_CAP) begin
            m_q.delete();
            m_due.delete();
            m_ovf      = 0;
            m_primed   = 0;
            m_prev_pin = CAP_IN;
            return;
        end
        if (CAP_IN != m_prev_pin &&
            (EDGE_SEL == 2'b11 || (EDGE_SEL == 2'b01 && CAP_IN) || (EDGE_SEL == 2'b10 && !CAP_IN)))
            m_due.push_back(cyc + 3);
        m_prev_pin = CAP_IN;
        push_now = 0;
        if (m_due.size() > 0 && m_due[0] == cyc) begin
            void'(m_due.pop_front());
            push_now = 1;
        end
        pop_now = CAP_RD && (m_q.size() > 0);
        drop    = push_now && (m_q.size() == DEPTH) && !pop_now;
        if (push_now) begin
`ifdef CAP_DELTA_EN
            if (!m_primed)         v = 0;
            else if (tmr >= m_last) v = tmr - m_last;
            else                    v = tmr + pr + 1 - m_last;
            m_primed = 1;
            m_last   = tmr;
`else
            v = tmr;
`endif
        end
        if (pop_now) void'(m_q.pop_front());
        if (push_now && !drop) m_q.push_back(v[W-1:0]);
        if (drop)         m_ovf = 1;
        else if (OVF_CLR) m_ovf = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        tmr = (tmr == pr) ? 0 : tmr + 1;
        cyc++;
    endtask

    task automatic check_model(input string tag);
        int exp_cnt;
        int exp_data;
        exp_cnt  = m_q.size();
        exp_data = (exp_cnt > 0) ? int'(m_q[0]) : 0;
        chk({tag, " cnt"},   CAP_CNT,   exp_cnt);
        chk({tag, " valid"}, CAP_VALID, (exp_cnt > 0) ? 1 : 0);
        chk({tag, " irq"},   CAP_IRQ,   (exp_cnt > 0) ? 1 : 0);
        chk({tag, " ovf"},   CAP_OVF,   m_ovf ? 1 : 0);
        chk({tag, " data"},  CAP_DATA,  exp_data);
    endtask

    typedef struct {
        bit       en;
        bit [1:0] es;
        bit       pin;
        bit       rd;
        bit       clr;
        int       cnt;
        bit       ovf;
        int       data;
    } vec_t;

    function automatic vec_t mk(input bit en, input bit [1:0] es, input bit pin, input bit rd,
                                input bit clr, input int cnt, input bit ovf, input int data);
        vec_t v;
        v.en = en; v.es = es; v.pin = pin; v.rd = rd; v.clr = clr;
        v.cnt = cnt; v.ovf = ovf; v.data = data;
        return v;
    endfunction

    vec_t tbl[30];

    initial begin
        rst = 1'b0; EN_CAP = 1'b0; EDGE_SEL = 2'b00; CAP_IN = 1'b0;
        CAP_RD = 1'b0; OVF_CLR = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset cnt",   CAP_CNT,   0);
        chk("reset valid", CAP_VALID, 0);
        chk("reset irq",   CAP_IRQ,   0);
        chk("reset ovf",   CAP_OVF,   0);
        chk("reset data",  CAP_DATA,  0);
        rst = 1'b1;
        tmr = 0;
        cyc = 0;

        // Row r is applied while TMR == r; expectations are after that edge.
        tbl[0]  = mk(1, 2'b01, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 2'b01, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 2'b01, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 2'b01, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 2'b01, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 2'b01, 1, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 2'b01, 1, 0, 0, 0, 0, 0);
        tbl[7]  = mk(1, 2'b01, 1, 0, 0, 0, 0, 0);
        tbl[8]  = mk(1, 2'b01, 1, 0, 0, 1, 0, 8);
        tbl[9]  = mk(1, 2'b11, 1, 1, 0, 0, 0, 0);
        tbl[10] = mk(1, 2'b11, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk(1, 2'b11, 1, 0, 0, 0, 0, 0);
        tbl[12] = mk(1, 2'b11, 0, 0, 0, 0, 0, 0);
        tbl[13] = mk(1, 2'b11, 1, 0, 0, 1, 0, 13);
        tbl[14] = mk(1, 2'b11, 0, 0, 0, 2, 0, 13);
        tbl[15] = mk(1, 2'b11, 0, 0, 0, 3, 0, 13);
        tbl[16] = mk(1, 2'b11, 0, 0, 0, 4, 0, 13);
        tbl[17] = mk(1, 2'b11, 0, 0, 0, 4, 1, 13);
        tbl[18] = mk(1, 2'b11, 1, 0, 1, 4, 0, 13);
        tbl[19] = mk(1, 2'b11, 1, 0, 0, 4, 0, 13);
        tbl[20] = mk(1, 2'b11, 1, 0, 0, 4, 0, 13);
        tbl[21] = mk(1, 2'b11, 1, 1, 0, 4, 0, 14);
        tbl[22] = mk(1, 2'b11, 1, 0, 0, 4, 0, 14);
        tbl[23] = mk(1, 2'b11, 0, 0, 0, 4, 0, 14);
        tbl[24] = mk(1, 2'b11, 0, 0, 0, 4, 0, 14);
        tbl[25] = mk(1, 2'b11, 0, 0, 0, 4, 0, 14);
        tbl[26] = mk(1, 2'b11, 0, 0, 1, 4, 1, 14);
        tbl[27] = mk(1, 2'b11, 0, 1, 0, 3, 1, 15);
        tbl[28] = mk(0, 2'b11, 0, 0, 0, 0, 0, 0);
        tbl[29] = mk(0, 2'b11, 0, 1, 0, 0, 0, 0);

        for (int i = 0; i < 30; i++) begin
            EN_CAP = tbl[i].en; EDGE_SEL = tbl[i].es; CAP_IN = tbl[i].pin;
            CAP_RD = tbl[i].rd; OVF_CLR = tbl[i].clr;
            tick();
            chk($sformatf("vec%0d cnt", i),   CAP_CNT,   tbl[i].cnt);
            chk($sformatf("vec%0d valid", i), CAP_VALID, (tbl[i].cnt != 0) ? 1 : 0);
            chk($sformatf("vec%0d irq", i),   CAP_IRQ,   (tbl[i].cnt != 0) ? 1 : 0);
            chk($sformatf("vec%0d ovf", i),   CAP_OVF,   tbl[i].ovf ? 1 : 0);
`ifndef CAP_DELTA_EN
            chk($sformatf("vec%0d data", i),  CAP_DATA,  tbl[i].data);
`endif
        end

        // Randomized segments with a wrapping timer
        pr = 150;
        tmr = 0;
        for (int seg = 0; seg < 8; seg++) begin
            EN_CAP = 1'b0; CAP_RD = 1'b0; OVF_CLR = 1'b0;
            tick(); tick();
            check_model("flush");
            EN_CAP = 1'b1;
            EDGE_SEL = 2'($urandom_range(0, 3));
            repeat (5) tick();
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(0, 2) == 0) CAP_IN = ~CAP_IN;
                CAP_RD  = ($urandom_range(0, 3) == 0);
                OVF_CLR = ($urandom_range(0, 7) == 0);
                tick();
                check_model("rand");
            end
            CAP_RD = 1'b0; OVF_CLR = 1'b0;
        end

`ifdef CAP_DELTA_EN
        // Delta mode: captures sampled at TMR 90 and then 10 with PR = 99
        EN_CAP = 1'b0; CAP_RD = 1'b0; OVF_CLR = 1'b0;
        tick(); tick();
        pr = 99; tmr = 80; EN_CAP = 1'b1; EDGE_SEL = 2'b11;
        for (int i = 0; i < 200 && tmr != 87; i++) tick();
        CAP_IN = ~CAP_IN;
        repeat (4) tick();
        chk("delta first cnt",  CAP_CNT,  1);
        chk("delta first data", CAP_DATA, 0);
        CAP_RD = 1'b1; tick(); CAP_RD = 1'b0;
        for (int i = 0; i < 200 && tmr != 7; i++) tick();
        CAP_IN = ~CAP_IN;
        repeat (4) tick();
        chk("delta second cnt",  CAP_CNT,  1);
        chk("delta second data", CAP_DATA, 20);
`endif

        // Asynchronous reset with pending data
        EN_CAP = 1'b0; CAP_RD = 1'b0; OVF_CLR = 1'b0;
        tick(); tick();
        EN_CAP = 1'b1; EDGE_SEL = 2'b11;
        repeat (5) tick();
        CAP_IN = ~CAP_IN;
        repeat (4) tick();
        chk("pre-reset valid", CAP_VALID, 1);
        #2 rst = 1'b0;
        #1;
        chk("async rst cnt",   CAP_CNT,   0);
        chk("async rst valid", CAP_VALID, 0);
        chk("async rst irq",   CAP_IRQ,   0);
        chk("async rst ovf",   CAP_OVF,   0);
        chk("async rst data",  CAP_DATA,  0);
        @(posedge clk);
        #1 rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
